// File: rtl/load_store_master.sv
// load_store_master
//   Multi-cycle load/store initiator between the CPU datapath and the
//   word-wide data memory / memory-mapped IO responder. The responder only
//   writes whole words, so byte and halfword stores are done as
//   read-modify-write.
//
// Ports
//   CLK, RESET             clock (rising edge), asynchronous active-high reset
//   ReqValid/ReqReady      CPU request handshake (ReqReady high only in IDLE)
//   ReqWrite, Funct3       1 = store; RISC-V width code (B, H, W, BU, HU)
//   Addr, StoreData        byte address, store data (low bits for sub-word)
//   RespValid              one-cycle completion pulse
//   LoadData               extended load result (0 for stores and faults)
//   Fault                  misaligned, illegal Funct3 or sub-word IO store
//   MemA, MemWD, MemWE     responder word address, write data, write enable
//   MemRD                  responder read data, combinational from MemA
//
// state | meaning
// IDLE  | ready for a request
// RD    | MemA driven, MemRD captured at the end of the cycle
// WR    | MemWE high for this single cycle
// RESP  | RespValid pulse, Fault = 0
// ERR   | RespValid pulse, Fault = 1, no memory access
module load_store_master #(
  parameter logic [31:0] IO_ADDR = 32'hFFFF_FFFC
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic        RespValid,
  output logic [31:0] LoadData,
  output logic        Fault,
  output logic [31:0] MemA,
  output logic [31:0] MemWD,
  output logic        MemWE,
  input  logic [31:0] MemRD
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_RESP, S_ERR} state_t;

  state_t      state, state_nxt;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
  logic        write_q;
  logic [15:0] sdata_q;
  logic [31:0] word_q;
  logic        accept;
  logic        io_hit;
  logic        req_fault;
  logic [31:0] merged;
  logic [31:0] extended;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign accept = ReqValid && (state == S_IDLE);
  assign io_hit = ({Addr[31:2], 2'b00} == IO_ADDR);
  assign MemWD  = word_q;

  // The IO port only accepts whole-word writes, so sub-word stores there
  // are rejected rather than turned into a read-modify-write of an input.
  always_comb begin
    req_fault = 1'b0;
    case (Funct3)
      3'b000:  req_fault = ReqWrite && io_hit;
      3'b001:  req_fault = Addr[0] || (ReqWrite && io_hit);
      3'b010:  req_fault = (Addr[1:0] != 2'b00);
      3'b100:  req_fault = ReqWrite;
      3'b101:  req_fault = ReqWrite || Addr[0];
      default: req_fault = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ReqReady  = 1'b0;
    MemWE     = 1'b0;
    case (state)
      S_IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          if (req_fault)                           state_nxt = S_ERR;
          else if (ReqWrite && Funct3 == 3'b010)   state_nxt = S_WR;
          else                                     state_nxt = S_RD;
        end
      end
      S_RD:    state_nxt = write_q ? S_WR : S_RESP;
      S_WR: begin
        MemWE     = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rd_byte = MemRD[{lane_q, 3'b000} +: 8];
  assign rd_half = MemRD[{lane_q[1], 4'b0000} +: 16];

  // Replace the addressed lane of the word just read; funct3_q[0] set means halfword.
  always_comb begin
    merged = MemRD;
    if (funct3_q[0]) merged[{lane_q[1], 4'b0000} +: 16] = sdata_q;
    else             merged[{lane_q, 3'b000} +: 8]      = sdata_q[7:0];
  end

  always_comb begin
    case (funct3_q)
      3'b000:  extended = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  extended = {{16{rd_half[15]}}, rd_half};
      3'b100:  extended = {24'h0, rd_byte};
      3'b101:  extended = {16'h0, rd_half};
      default: extended = MemRD;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lane_q    <= 2'b00;
      funct3_q  <= 3'b000;
      write_q   <= 1'b0;
      sdata_q   <= 16'h0;
      word_q    <= 32'h0;
      MemA      <= 32'h0;
      RespValid <= 1'b0;
      Fault     <= 1'b0;
      LoadData  <= 32'h0;
    end else begin
      RespValid <= (state_nxt == S_RESP) || (state_nxt == S_ERR);
      Fault     <= (state_nxt == S_ERR);
      if (accept) begin
        lane_q   <= Addr[1:0];
        funct3_q <= Funct3;
        write_q  <= ReqWrite;
        sdata_q  <= StoreData[15:0];
        MemA     <= {Addr[31:2], 2'b00};
        // A full-word store goes straight to WR, so its data is staged here.
        word_q   <= StoreData;
      end
      if (state == S_RD) word_q <= write_q ? merged : MemRD;
      if (state_nxt == S_ERR)             LoadData <= 32'h0;
      else if (state == S_RD && !write_q) LoadData <= extended;
      else if (state == S_WR)             LoadData <= 32'h0;
    end
  end

endmodule

// File: tb/tb_load_store_master.sv
module tb_load_store_master;

  localparam logic [31:0] IO_ADDR = 32'hFFFF_FFFC;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ReqValid, ReqReady, ReqWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, StoreData;
  logic        RespValid, Fault, MemWE;
  logic [31:0] LoadData, MemA, MemWD, MemRD;

  logic [31:0] mem [0:15];
  logic [31:0] io_in, io_out;
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_val;

  logic [7:0]  ref_b [0:63];
  logic [31:0] ref_io;
  logic [31:0] last_ld;
  int          n_tests, n_fail;

  always #5 CLK = ~CLK;

  load_store_master #(.IO_ADDR(IO_ADDR)) dut (
    .CLK(CLK), .RESET(RESET),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .Funct3(Funct3), .Addr(Addr), .StoreData(StoreData),
    .RespValid(RespValid), .LoadData(LoadData), .Fault(Fault),
    .MemA(MemA), .MemWD(MemWD), .MemWE(MemWE), .MemRD(MemRD)
  );

  // Responder: 16 words of RAM at 0x00-0x3F plus the IO port.
  assign MemRD = (MemA == IO_ADDR) ? io_in :
                 (MemA[31:6] == 26'h0) ? mem[MemA[5:2]] : 32'h0;

  always @(posedge CLK) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_val;
      io_out      <= 32'h0;
    end else if (MemWE) begin
      if (MemA == IO_ADDR)          io_out <= MemWD;
      else if (MemA[31:6] == 26'h0) mem[MemA[5:2]] <= MemWD;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int base;
    if ({a[31:2], 2'b00} == IO_ADDR) return io_in;
    if (a >= 32'd64) return 32'h0;
    base = int'(a[5:2]) * 4;
    return {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit ref_fault(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    if (wr && (f3 == 3'b100 || f3 == 3'b101)) return 1'b1;
    if ((a % sz) != 0) return 1'b1;
    if (wr && sz < 4 && (a & ~32'd3) == IO_ADDR) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input bit hold, output logic [31:0] ld_obs);
    int sz = size_of(f3);
    bit ex_f = ref_fault(wr, f3, a);
    logic [31:0] w = ref_word(a);
    logic [31:0] mask, v, exp_ld, exp_wd, exp_ma;
    int exp_lat, exp_we, exp_wecyc;
    int cyc, lat, we_cnt, we_cyc;
    bit got, busy_rdy, ma_bad;
    logic [31:0] wa, wd;

    mask   = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    v      = (w >> (8 * int'(a[1:0]))) & mask;
    if (f3[2] == 1'b0 && sz < 4 && v[8*sz-1]) v = v | ~mask;
    exp_ld = (ex_f || wr) ? 32'h0 : v;
    exp_ma = a & ~32'd3;
    exp_wd = 32'h0;
    if (wr && !ex_f) begin
      if (exp_ma == IO_ADDR) begin
        ref_io = sd;
        exp_wd = sd;
      end else begin
        for (int i = 0; i < sz; i++) ref_b[int'(a) + i] = 8'((sd >> (8 * i)) & 32'hFF);
        exp_wd = ref_word(a);
      end
    end
    exp_lat   = ex_f ? 1 : (!wr ? 2 : (sz == 4 ? 2 : 3));
    exp_we    = (wr && !ex_f) ? 1 : 0;
    exp_wecyc = (sz == 4) ? 1 : 2;

    @(negedge CLK);
    check("idle_rv", {31'h0, RespValid}, 32'h0);
    check("ld_hold", LoadData, last_ld);
    check("idle_rdy", {31'h0, ReqReady}, 32'h1);
    ReqValid = 1'b1; ReqWrite = wr; Funct3 = f3; Addr = a; StoreData = sd;
    cyc = 0; got = 1'b0; we_cnt = 0; we_cyc = 0; busy_rdy = 1'b0; ma_bad = 1'b0;
    wa = 32'h0; wd = 32'h0;
    while (!got && cyc < 8) begin
      @(negedge CLK);
      cyc++;
      if (ReqReady) busy_rdy = 1'b1;
      if (MemA !== exp_ma) ma_bad = 1'b1;
      if (MemWE) begin
        we_cnt++; we_cyc = cyc; wa = MemA; wd = MemWD;
      end
      if (RespValid) got = 1'b1;
      if (!hold) ReqValid = 1'b0;
    end
    lat = got ? cyc : 99;
    check("latency", lat, exp_lat);
    check("fault", {31'h0, Fault}, {31'h0, ex_f});
    check("load_data", LoadData, exp_ld);
    check("we_count", we_cnt, exp_we);
    check("busy_ready", {31'h0, busy_rdy}, 32'h0);
    check("mema_hold", {31'h0, ma_bad}, 32'h0);
    if (exp_we == 1) begin
      check("we_cycle", we_cyc, exp_wecyc);
      check("we_addr", wa, exp_ma);
      check("we_data", wd, exp_wd);
    end
    last_ld = exp_ld;
    ld_obs  = LoadData;
  endtask

  initial begin
    logic [31:0] ld, a, sd;
    logic [2:0]  f3;
    logic        wr;
    bit          extra;

    n_tests = 0; n_fail = 0; last_ld = 32'h0; ref_io = 32'h0;
    RESET = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; Funct3 = 3'b000;
    Addr = 32'h0; StoreData = 32'h0; io_in = 32'h0;
    pl_en = 1'b1; pl_idx = 4'h0; pl_val = 32'h0;

    for (int i = 0; i < 16; i++) begin
      pl_idx = 4'(i);
      pl_val = (i == 4) ? 32'h8077_66F5 : $urandom;
      for (int k = 0; k < 4; k++) ref_b[4*i+k] = pl_val[8*k +: 8];
      @(negedge CLK);
    end
    pl_en = 1'b0;
    @(negedge CLK);
    check("rst_respvalid", {31'h0, RespValid}, 32'h0);
    check("rst_loaddata", LoadData, 32'h0);
    check("rst_fault", {31'h0, Fault}, 32'h0);
    check("rst_mema", MemA, 32'h0);
    check("rst_memwd", MemWD, 32'h0);
    check("rst_memwe", {31'h0, MemWE}, 32'h0);
    check("rst_ready", {31'h0, ReqReady}, 32'h1);
    RESET = 1'b0;

    do_req(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, ld); check("lb_0x10", ld, 32'hFFFF_FFF5);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, ld); check("lbu_0x13", ld, 32'h0000_0080);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, ld); check("lh_0x12", ld, 32'hFFFF_8077);
    do_req(1'b0, 3'b101, 32'h10, 32'h0, 1'b0, ld); check("lhu_0x10", ld, 32'h0000_66F5);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, ld); check("lw_0x10", ld, 32'h8077_66F5);

    do_req(1'b1, 3'b000, 32'h11, 32'h0000_00AB, 1'b0, ld);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, ld); check("lw_after_sb", ld, 32'h8077_ABF5);

    do_req(1'b1, 3'b010, IO_ADDR, 32'h1234_5678, 1'b0, ld);
    check("io_written", io_out, 32'h1234_5678);
    io_in = 32'hCAFE_0001;
    do_req(1'b0, 3'b010, IO_ADDR, 32'h0, 1'b0, ld); check("lw_io", ld, 32'hCAFE_0001);

    do_req(1'b0, 3'b001, 32'h11, 32'h0, 1'b0, ld);
    do_req(1'b1, 3'b010, 32'h12, 32'hDEAD_BEEF, 1'b0, ld);
    do_req(1'b1, 3'b000, 32'hFFFF_FFFD, 32'h55, 1'b0, ld);
    do_req(1'b0, 3'b011, 32'h10, 32'h0, 1'b0, ld);

    // ReqValid kept high through the whole transaction.
    do_req(1'b0, 3'b010, 32'h14, 32'h0, 1'b1, ld);
    @(negedge CLK);
    ReqValid = 1'b0;
    extra = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (RespValid) extra = 1'b1;
    end
    check("no_reaccept", {31'h0, extra}, 32'h0);

    // Reset in the WR cycle of a byte store.
    @(negedge CLK);
    ReqValid = 1'b1; ReqWrite = 1'b1; Funct3 = 3'b000; Addr = 32'h11; StoreData = 32'h0000_0033;
    @(negedge CLK);
    ReqValid = 1'b0;
    @(negedge CLK);
    check("rst_wr_we_before", {31'h0, MemWE}, 32'h1);
    RESET = 1'b1;
    #1;
    check("rst_wr_we_fall", {31'h0, MemWE}, 32'h0);
    @(negedge CLK);
    check("rst_wr_no_resp", {31'h0, RespValid}, 32'h0);
    check("rst_wr_mem", mem[4], ref_word(32'h10));
    RESET = 1'b0;
    last_ld = 32'h0;
    @(negedge CLK);
    check("rst_wr_ready", {31'h0, ReqReady}, 32'h1);
    check("rst_wr_quiet", {31'h0, RespValid}, 32'h0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, ld); check("lw_after_rst", ld, 32'h8077_ABF5);

    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(0, 7));
      wr = 1'($urandom_range(0, 1));
      sd = $urandom;
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = IO_ADDR | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(f3) - 1);
      io_in = $urandom;
      do_req(wr, f3, a, sd, 1'b0, ld);
    end

    @(negedge CLK);
    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_word(32'(4 * i)));
    check("final_io", io_out, ref_io);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_master.md
Name: load_store_master

Overview:
- Multi-cycle initiator that sits between the CPU datapath and the word-wide data memory / memory-mapped IO responder.
- Accepts byte, halfword and word loads and stores from the CPU over a valid/ready handshake.
- Drives the responder's address, write-data and write-enable inputs, and returns sign- or zero-extended load data.
- The responder only writes whole words, so sub-word stores are done as read-modify-write.

Parameters:
IO_ADDR, 32'hFFFF_FFFC, word address decoded by the responder as the IO port.

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-high reset
ReqValid  input  1  CPU request present
ReqReady  output  1  high only in IDLE; request accepted when ReqValid && ReqReady at a CLK edge
ReqWrite  input  1  1 = store, 0 = load
Funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
Addr  input  32  byte address
StoreData  input  32  store data, low bits used for sub-word stores
RespValid  output  1  one-cycle completion pulse, no back-pressure
LoadData  output  32  extended load result, valid with RespValid; 0 for stores and faults
Fault  output  1  valid with RespValid: misaligned, illegal Funct3, or sub-word IO store
MemA  output  32  responder address, always word-aligned {Addr[31:2],2'b00}
MemWD  output  32  responder write data
MemWE  output  1  responder write enable
MemRD  input  32  responder read data, combinational from MemA

Behaviour:
- Reset state: asynchronous to IDLE; all of the following are 0: RespValid, LoadData, Fault, MemA, MemWD, MemWE, internal word register.
- ReqReady is combinational (state==IDLE), so it is 1 immediately after reset.
- States: IDLE, RD, WR, RESP, ERR.
- On acceptance (cycle N), latch Addr, Funct3, ReqWrite and StoreData. ReqValid is ignored outside IDLE.
- Fault conditions, checked at acceptance:
  - Funct3 in {011,110,111}.
  - Store with Funct3 100 or 101.
  - H/HU with Addr[0]!=0.
  - W with Addr[1:0]!=0.
  - Sub-word store whose word address equals IDLE_ADDR... precisely: whose word address equals IO_ADDR (the IO port is write-only as a whole word).
  - Any fault goes to ERR.
- ERR (cycle N+1): RespValid=1, Fault=1, LoadData=0, no memory access; then IDLE.
- Load: IDLE -> RD (N+1) -> RESP (N+2).
  - In RD, MemA is driven and MemRD is captured at the N+1 edge.
  - Lane select is Addr[1:0] for bytes and Addr[1] for halves.
  - B/H are sign-extended; BU/HU are zero-extended; W passes through.
  - A load from IO_ADDR returns whatever the responder returns (CPU input); it is not special-cased.
- SW: IDLE -> WR (N+1) -> RESP (N+2). No read is performed.
- SB/SH: IDLE -> RD (N+1) -> WR (N+2) -> RESP (N+3).
  - Captured word is merged: the selected byte/half lane is replaced by StoreData[7:0]/[15:0]; other lanes are preserved.
- WR: MemWE=1 for exactly that one cycle, with MemWD = merged or full word; the responder writes at the end-of-cycle edge.
- MemWE is 0 in every other state.
- RESP: RespValid=1 for one cycle, Fault=0; then IDLE.
  - The next request can be accepted in the cycle after RESP.
- RespValid and Fault are registered outputs. LoadData holds its value until the next RESP/ERR.
- MemA holds the latched word address in every non-IDLE state.
- Reset mid-operation: MemWE deasserts asynchronously. The in-flight access is abandoned with no response and no write. With RESET held across the edge, memory is unchanged.

Test Plan:
1. Memory word 0x10 = 0x8077_66F5; LB 0x10 -> RespValid at N+2, LoadData 0xFFFF_FFF5, Fault 0, MemWE never asserted.
2. Same word: LBU 0x13 -> 0x0000_0080; LH 0x12 -> 0xFFFF_8077; LHU 0x10 -> 0x0000_66F5; LW 0x10 -> 0x8077_66F5.
3. SB 0x11, StoreData 0x0000_00AB -> MemWE only at N+2 with MemA 0x10, MemWD 0x8077_ABF5; RespValid at N+3; follow-up LW 0x10 returns 0x8077_ABF5.
4. SW IO_ADDR, StoreData 0x1234_5678 -> MemWE at N+1, MemA 0xFFFF_FFFC, MemWD 0x1234_5678, RespValid at N+2; LW IO_ADDR with CPU input 0xCAFE_0001 -> LoadData 0xCAFE_0001.
5. Fault cases, each giving RespValid and Fault at N+1, LoadData 0, no MemWE:
   - LH 0x11
   - SW 0x12
   - SB 0xFFFF_FFFD
   - Funct3 011
   - ReqValid held high during the busy state is not re-accepted until IDLE.
6. Assert RESET during the WR cycle of SB 0x11 -> MemWE falls immediately, word 0x10 unchanged, no RespValid; after release ReqReady=1 and the next LW completes normally.
